coffee_dispense_ctrl: RTL and testbench
=======================================

# coffee_dispense_ctrl

Back-end controller of the coffee vending machine. It accepts a completed sale from the coin-acceptance FSM, which provides the coffee flag plus 50/100 change flags. It then drives the coffee valve for a fixed time and pays the change coin by coin through a req/ack handshake with the coin ejector. It also keeps per-tube coin inventory and flags sales it could not fully refund.

## Interface
- `CAFE_CYCLES`, default 8: number of cycles the valve is held high; legal values are 1..255.
- `TUBE_MAX`, default 15: saturation value of each coin-tube counter; counters are 4 bits wide.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `start` in 1: sale request; sampled only in IDLE.
- `cafe_in` in 1: sale paid; `start` is ignored while this is 0.
- `t50_in` in 1: refund 50 requested; sampled with `start`.
- `t100_in` in 1: refund 100 requested; sampled with `start`.
- `refill50` in 1: add one 50 coin to its tube, one coin per cycle high.
- `refill100` in 1: add one 100 coin to its tube, one coin per cycle high.
- `eject_ack` in 1: ejector acknowledge; four-phase handshake.
- `valve` out 1: coffee valve drive.
- `eject_req` out 1: eject one coin.
- `eject_sel` out 1: coin type, 0 = 50, 1 = 100; stable while `eject_req` is high.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse when a sale finishes.
- `short_change` out 1: sticky flag meaning the refund was incomplete; cleared on the next accepted start.
- `cnt50` out 4: current count of the 50 tube.
- `cnt100` out 4: current count of the 100 tube.
- `state` out 3: current state encoding.

## Operation
- States: IDLE = 0, VALVE = 1, PICK = 2, EJECT = 3, DROP = 4, DONE = 5. Codes 6 and 7 go to IDLE.
- `rem` is a 2-bit count of outstanding refund in 50-units.
- IDLE:
  - `start & cafe_in` latches `rem = t50_in + 2*t100_in` (range 0..3), clears `short_change`, loads the valve timer, and moves to VALVE.
  - Otherwise the block stays in IDLE.
- VALVE: `valve` = 1; the timer counts down; the block moves to PICK after exactly `CAFE_CYCLES` cycles.
- PICK, in priority order:
  - `rem == 0` → DONE.
  - `rem >= 2` and `cnt100 > 0` → select 100 → EJECT.
  - `cnt50 > 0` → select 50 → EJECT.
  - Otherwise set `short_change` → DONE, with no eject.
- EJECT:
  - `eject_req` = 1 and `eject_sel` is held at the selected coin.
  - On `eject_ack` = 1: decrement the selected tube, subtract 2 or 1 from `rem` (100 or 50), and move to DROP.
- DROP: `eject_req` = 0; the block waits for `eject_ack` = 0, then moves to PICK.
- DONE: `done` = 1 for one cycle, then IDLE.
- Refill:
  - Active in every state.
  - Saturates at `TUBE_MAX`.
  - Refill and decrement of the same tube in the same cycle leaves the count unchanged.
- All outputs are Moore outputs, decoded from registered state; `eject_sel` comes from a register.

## Timing
- Reset values:
  - State IDLE; `rem`, timer, `cnt50`, `cnt100` all 0.
  - `short_change` = 0.
  - `valve`, `eject_req`, `eject_sel`, `busy`, `done` all 0; `state` = 0.
- Reset is asynchronous, so assertion mid-sale drops `valve` and `eject_req` immediately; tube counts are also lost.
- Latency, with `start` sampled at edge N:
  - VALVE from N+1; `valve` high for cycles N+1 .. N+`CAFE_CYCLES`.
  - PICK at N+`CAFE_CYCLES`+1.
  - EJECT at N+`CAFE_CYCLES`+2.
- Zero refund: `done` at N+`CAFE_CYCLES`+2.
- Handshake:
  - `eject_req` rises the cycle after PICK.
  - `eject_req` falls the cycle after `eject_ack` is sampled high.
  - The next request is issued no earlier than 2 cycles after `eject_ack` is seen low.
- `start` while `busy` is ignored. `eject_ack` outside EJECT/DROP is ignored.

## Structure
- Package `vending_pkg`:
  - The state enum.
  - Coin-select constants COIN50 = 0 and COIN100 = 1.
  - The unit-value constant (50).
  - Also used by the coin-acceptance FSM for shared coin definitions.
- One sub-module, `coin_tube`, instantiated twice: a 4-bit saturating up/down counter with `inc`, `dec`, and a count output; `dec` at 0 is blocked.

## Test plan
- Reset: assert `rst` mid-EJECT → `eject_req`, `valve`, and `busy` go to 0 immediately; after release, `cnt50` = `cnt100` = 0 and `state` = 0.
- No refund, `CAFE_CYCLES` = 4, start at N with `t50_in` = `t100_in` = 0:
  - `valve` high N+1..N+4.
  - `done` at N+6.
  - `eject_req` never asserted.
- Refund 150 (`t50_in` = `t100_in` = 1) with 3 coins in each tube:
  - Two handshakes in order: sel = 1, then sel = 0.
  - Final `cnt100` = 2, `cnt50` = 2; `short_change` = 0.
- Refund 100 with `cnt100` = 0 and `cnt50` = 3: two 50 ejects, final `cnt50` = 1.
- Refund 50 with both tubes empty: no `eject_req`, `short_change` = 1, `done` pulses. The next start clears `short_change`.
- Counter edge cases:
  - Hold `refill50` for 20 cycles → `cnt50` = 15.
  - `refill100` in the same cycle as a 100 ack → `cnt100` unchanged.
  - `start` during VALVE → ignored.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: dispense FSM states and coin encodings.
// Also imported by the coin-acceptance FSM.
package vending_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_VALVE = 3'd1,
    ST_PICK  = 3'd2,
    ST_EJECT = 3'd3,
    ST_DROP  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic COIN50  = 1'b0;
  localparam logic COIN100 = 1'b1;

  localparam int unsigned UNIT_VALUE = 50;

endpackage

// File: rtl/coffee_dispense_ctrl_coin_tube.sv
// 4-bit saturating coin-tube counter; a simultaneous refill and eject cancel out.
module coin_tube #(
  parameter int unsigned TUBE_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] count
);

  logic [3:0] count_nxt;
  logic       dec_ok;

  always_comb begin
    dec_ok    = dec && (count != '0);
    count_nxt = count;
    if (inc && !dec_ok) begin
      if (count < 4'(TUBE_MAX)) count_nxt = count + 4'd1;
    end else if (dec_ok && !inc) begin
      count_nxt = count - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= count_nxt;
  end

endmodule

// File: rtl/coffee_dispense_ctrl.sv
// Vending back-end: runs the coffee valve for a fixed time, then pays change
// coin by coin over a four-phase req/ack handshake while tracking tube stock.
module coffee_dispense_ctrl
  import vending_pkg::*;
#(
  parameter int unsigned CAFE_CYCLES = 8,
  parameter int unsigned TUBE_MAX    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cafe_in,
  input  logic       t50_in,
  input  logic       t100_in,
  input  logic       refill50,
  input  logic       refill100,
  input  logic       eject_ack,
  output logic       valve,
  output logic       eject_req,
  output logic       eject_sel,
  output logic       busy,
  output logic       done,
  output logic       short_change,
  output logic [3:0] cnt50,
  output logic [3:0] cnt100,
  output logic [2:0] state
);

  state_t     cur, nxt;
  logic [7:0] timer, timer_nxt;
  logic [1:0] rem, rem_nxt;
  logic       sel, sel_nxt;
  logic       short_r, short_nxt;
  logic       dec50, dec100;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur     <= ST_IDLE;
      timer   <= '0;
      rem     <= '0;
      sel     <= COIN50;
      short_r <= 1'b0;
    end else begin
      cur     <= nxt;
      timer   <= timer_nxt;
      rem     <= rem_nxt;
      sel     <= sel_nxt;
      short_r <= short_nxt;
    end
  end

  always_comb begin
    nxt       = cur;
    timer_nxt = timer;
    rem_nxt   = rem;
    sel_nxt   = sel;
    short_nxt = short_r;
    dec50     = 1'b0;
    dec100    = 1'b0;
    case (cur)
      ST_IDLE: begin
        if (start && cafe_in) begin
          // {t100,t50} is exactly t50 + 2*t100 in 50-units
          rem_nxt   = {t100_in, t50_in};
          short_nxt = 1'b0;
          timer_nxt = 8'(CAFE_CYCLES);
          nxt       = ST_VALVE;
        end
      end
      ST_VALVE: begin
        if (timer <= 8'd1) nxt = ST_PICK;
        else               timer_nxt = timer - 8'd1;
      end
      ST_PICK: begin
        if (rem == 2'd0) begin
          nxt = ST_DONE;
        end else if (rem >= 2'd2 && cnt100 != '0) begin
          sel_nxt = COIN100;
          nxt     = ST_EJECT;
        end else if (cnt50 != '0) begin
          sel_nxt = COIN50;
          nxt     = ST_EJECT;
        end else begin
          short_nxt = 1'b1;
          nxt       = ST_DONE;
        end
      end
      ST_EJECT: begin
        if (eject_ack) begin
          if (sel == COIN100) begin
            dec100  = 1'b1;
            rem_nxt = rem - 2'd2;
          end else begin
            dec50   = 1'b1;
            rem_nxt = rem - 2'd1;
          end
          nxt = ST_DROP;
        end
      end
      ST_DROP: begin
        if (!eject_ack) nxt = ST_PICK;
      end
      ST_DONE: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  coin_tube #(.TUBE_MAX(TUBE_MAX)) u_tube50 (
    .clk   (clk),
    .rst   (rst),
    .inc   (refill50),
    .dec   (dec50),
    .count (cnt50)
  );

  coin_tube #(.TUBE_MAX(TUBE_MAX)) u_tube100 (
    .clk   (clk),
    .rst   (rst),
    .inc   (refill100),
    .dec   (dec100),
    .count (cnt100)
  );

  assign valve        = (cur == ST_VALVE);
  assign eject_req    = (cur == ST_EJECT);
  assign busy         = (cur != ST_IDLE);
  assign done         = (cur == ST_DONE);
  assign eject_sel    = sel;
  assign short_change = short_r;
  assign state        = cur;

endmodule

// File: tb/tb_coffee_dispense_ctrl.sv
// Bench for coffee_dispense_ctrl: directed and random sales against a greedy
// change-payout model with an ejector that answers after random delays.
module tb_coffee_dispense_ctrl;

  localparam int unsigned C    = 4;
  localparam int unsigned TMAX = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, cafe_in = 1'b0, t50_in = 1'b0, t100_in = 1'b0;
  logic       refill50 = 1'b0, refill100 = 1'b0, eject_ack = 1'b0;
  logic       valve, eject_req, eject_sel, busy, done, short_change;
  logic [3:0] cnt50, cnt100;
  logic [2:0] state;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned m50 = 0, m100 = 0;

  coffee_dispense_ctrl #(.CAFE_CYCLES(C), .TUBE_MAX(TMAX)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cafe_in      (cafe_in),
    .t50_in       (t50_in),
    .t100_in      (t100_in),
    .refill50     (refill50),
    .refill100    (refill100),
    .eject_ack    (eject_ack),
    .valve        (valve),
    .eject_req    (eject_req),
    .eject_sel    (eject_sel),
    .busy         (busy),
    .done         (done),
    .short_change (short_change),
    .cnt50        (cnt50),
    .cnt100       (cnt100),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_cnt50"}, 32'(cnt50), m50);
    check({tag, "_cnt100"}, 32'(cnt100), m100);
  endtask

  task automatic do_refill(input int unsigned n50, input int unsigned n100);
    int unsigned n;
    n = (n50 > n100) ? n50 : n100;
    for (int unsigned i = 0; i < n; i++) begin
      refill50  = (i < n50);
      refill100 = (i < n100);
      step();
      if (i < n50)  m50  = (m50  < TMAX) ? m50 + 1  : TMAX;
      if (i < n100) m100 = (m100 < TMAX) ? m100 + 1 : TMAX;
    end
    refill50  = 1'b0;
    refill100 = 1'b0;
    check_counts("refill");
  endtask

  // One complete sale; expected coins come from greedy payout on the model tubes.
  task automatic run_sale(input logic t50, input logic t100, input bit refill_on_ack);
    int unsigned r, c50, c100;
    bit          exp_short;
    logic        coins[$];
    r = 32'(t50) + 2 * 32'(t100);
    c50 = m50;
    c100 = m100;
    exp_short = 1'b0;
    while (r > 0) begin
      if (r >= 2 && c100 > 0) begin
        coins.push_back(1'b1); c100--; r -= 2;
      end else if (c50 > 0) begin
        coins.push_back(1'b0); c50--; r -= 1;
      end else begin
        exp_short = 1'b1;
        break;
      end
    end

    start = 1'b1; cafe_in = 1'b1; t50_in = t50; t100_in = t100;
    step();
    start = 1'b0; t50_in = 1'b0; t100_in = 1'b0;
    check("sale_enter_state", 32'(state), 1);
    check("sale_short_cleared", 32'(short_change), 0);
    for (int unsigned k = 1; k <= C; k++) begin
      check("valve_high", 32'(valve), 1);
      check("valve_busy", 32'(busy), 1);
      start   = 1'($urandom_range(0, 1));
      t100_in = 1'($urandom_range(0, 1));
      step();
    end
    start = 1'b0; t100_in = 1'b0;
    check("pick_state", 32'(state), 2);
    check("pick_valve_low", 32'(valve), 0);

    foreach (coins[i]) begin
      bit      same_cycle_refill;
      int unsigned d;
      step();
      check("eject_req_high", 32'(eject_req), 1);
      check("eject_sel", 32'(eject_sel), 32'(coins[i]));
      d = $urandom_range(0, 2);
      for (int unsigned j = 0; j < d; j++) begin
        step();
        check("eject_req_hold", 32'(eject_req), 1);
        check("eject_sel_hold", 32'(eject_sel), 32'(coins[i]));
      end
      same_cycle_refill = refill_on_ack && coins[i];
      eject_ack = 1'b1;
      refill100 = same_cycle_refill;
      step();
      refill100 = 1'b0;
      if (!same_cycle_refill) begin
        if (coins[i]) m100--;
        else          m50--;
      end
      check("drop_state", 32'(state), 4);
      check("drop_req_low", 32'(eject_req), 0);
      check_counts("eject");
      d = $urandom_range(0, 2);
      for (int unsigned j = 0; j < d; j++) begin
        step();
        check("drop_wait", 32'(state), 4);
      end
      eject_ack = 1'b0;
      step();
      check("repick_state", 32'(state), 2);
      check("repick_req_low", 32'(eject_req), 0);
    end

    step();
    check("done_pulse", 32'(done), 1);
    check("done_req_low", 32'(eject_req), 0);
    check("done_short", 32'(short_change), 32'(exp_short));
    step();
    check("done_cleared", 32'(done), 0);
    check("idle_busy", 32'(busy), 0);
    check("idle_state", 32'(state), 0);
    check("idle_short_sticky", 32'(short_change), 32'(exp_short));
    check_counts("sale");
  endtask

  initial begin
    // Reset values
    step(); step();
    check("rst_state", 32'(state), 0);
    check("rst_valve", 32'(valve), 0);
    check("rst_req", 32'(eject_req), 0);
    check("rst_sel", 32'(eject_sel), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_short", 32'(short_change), 0);
    check_counts("rst");
    rst = 1'b0;
    step();

    // start without payment is ignored
    start = 1'b1; cafe_in = 1'b0;
    step();
    start = 1'b0;
    check("unpaid_ignored", 32'(state), 0);
    // ack outside a handshake is ignored
    eject_ack = 1'b1;
    step();
    eject_ack = 1'b0;
    check("stray_ack_state", 32'(state), 0);

    run_sale(1'b0, 1'b0, 1'b0);            // no refund
    run_sale(1'b1, 1'b0, 1'b0);            // 50 with empty tubes -> short
    check("short_sticky_idle", 32'(short_change), 1);
    do_refill(3, 3);
    run_sale(1'b1, 1'b1, 1'b0);            // 150 -> 100 then 50
    check("after150_short", 32'(short_change), 0);
    run_sale(1'b0, 1'b1, 1'b0);
    run_sale(1'b0, 1'b1, 1'b0);            // drains the 100 tube
    do_refill(1, 0);                       // cnt50 = 3, cnt100 = 0
    run_sale(1'b0, 1'b1, 1'b0);            // 100 paid as two 50s
    check("two50_cnt50", 32'(cnt50), 1);
    do_refill(0, 2);
    run_sale(1'b0, 1'b1, 1'b1);            // refill100 coincides with the ack
    do_refill(20, 0);
    check("sat_cnt50", 32'(cnt50), 15);

    for (int unsigned n = 0; n < 12; n++) begin
      do_refill($urandom_range(0, 3), $urandom_range(0, 3));
      run_sale(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a handshake
    do_refill(2, 2);
    start = 1'b1; cafe_in = 1'b1; t50_in = 1'b1;
    step();
    start = 1'b0; t50_in = 1'b0;
    for (int unsigned k = 0; k < C + 1; k++) step();
    check("pre_rst_req", 32'(eject_req), 1);
    #3 rst = 1'b1;
    #1;
    check("async_rst_req", 32'(eject_req), 0);
    check("async_rst_valve", 32'(valve), 0);
    check("async_rst_busy", 32'(busy), 0);
    m50 = 0; m100 = 0;
    step();
    rst = 1'b0;
    step();
    check("post_rst_state", 32'(state), 0);
    check_counts("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
